// File: rtl/qracc_sram_ctrl.sv
// qracc_sram_ctrl: sequences the analog SRAM macro pins for single-word read/write requests.
// Build option QRACC_WRITE_VERIFY_EN adds a read-back check after every write (sticky wr_err_o).
module qracc_sram_ctrl #(
    parameter int numRows   = 128,
    parameter int numCols   = 32,
    parameter int pchCycles = 1,
    parameter int wlCycles  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rq_valid_i,
    input  logic                       rq_wr_i,
    input  logic [$clog2(numRows)-1:0] addr_i,
    input  logic [numCols-1:0]         wr_data_i,
    output logic                       rq_ready_o,
    output logic                       rd_valid_o,
    output logic [numCols-1:0]         rd_data_o,
    input  logic                       mac_en_i,
    output logic                       busy_o,
    output logic [numRows-1:0]         WL,
    output logic                       PCH,
    output logic                       WRITE,
    output logic [numCols-1:0]         WR_DATA,
    output logic [numCols-1:0]         CSEL,
    output logic                       SAEN,
    input  logic [numCols-1:0]         SA_OUT,
    output logic                       wr_err_o
);
    localparam int AW   = $clog2(numRows);
    localparam int MAXC = (pchCycles > wlCycles) ? pchCycles : wlCycles;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] PCH_LOAD = CW'(pchCycles - 1);
    localparam logic [CW-1:0] WL_LOAD  = CW'(wlCycles - 1);

    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_WL, W_REC, R_PCH, R_WL, R_SENSE, R_DONE
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [AW-1:0]     addr_q;
    logic [numCols-1:0] wdata_q;
    logic              accept;
    logic              sense_is_read;
    logic              wl_on;

    // Handshake: a request transfers on a rising edge where rq_valid_i && rq_ready_o;
    // ready is only offered in IDLE with MAC mode off, so payload is latched exactly once.
    assign rq_ready_o = (state == IDLE) && !mac_en_i && !rst;
    assign accept     = rq_valid_i && (state == IDLE) && !mac_en_i;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: if (accept) begin
                state_d = rq_wr_i ? W_SETUP : R_PCH;
                cnt_d   = rq_wr_i ? WL_LOAD : PCH_LOAD;
            end
            W_SETUP: begin
                state_d = W_WL;
                cnt_d   = WL_LOAD;
            end
            W_WL: if (cnt == '0) state_d = W_REC;
                  else           cnt_d   = cnt - CW'(1);
`ifdef QRACC_WRITE_VERIFY_EN
            W_REC: begin
                state_d = R_PCH;
                cnt_d   = PCH_LOAD;
            end
`else
            W_REC: state_d = IDLE;
`endif
            R_PCH: if (cnt == '0) begin
                state_d = R_WL;
                cnt_d   = WL_LOAD;
            end else begin
                cnt_d   = cnt - CW'(1);
            end
            R_WL: if (cnt == '0) state_d = R_SENSE;
                  else           cnt_d   = cnt - CW'(1);
            R_SENSE: state_d = sense_is_read ? R_DONE : IDLE;
            R_DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_o <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                addr_q  <= addr_i;
                wdata_q <= wr_data_i;
            end
            if (state == R_SENSE && sense_is_read)
                rd_data_o <= SA_OUT;
        end
    end

`ifdef QRACC_WRITE_VERIFY_EN
    logic verify_q;
    logic wr_err_q;

    // verify_q marks the R_* pass that follows a write as a check, not a host read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verify_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            if (accept)
                verify_q <= rq_wr_i;
            if (accept && rq_wr_i)
                wr_err_q <= 1'b0;
            else if (state == R_SENSE && verify_q && SA_OUT != wdata_q)
                wr_err_q <= 1'b1;
        end
    end

    assign sense_is_read = !verify_q;
    assign wr_err_o      = wr_err_q;
`else
    assign sense_is_read = 1'b1;
    assign wr_err_o      = 1'b0;
`endif

    // Analog controls decode from state and latched request only.
    assign busy_o     = (state != IDLE);
    assign rd_valid_o = (state == R_DONE);
    assign PCH        = (state == R_PCH);
    assign SAEN       = (state == R_SENSE);
    assign WRITE      = (state == W_SETUP) || (state == W_WL) || (state == W_REC);
    assign WR_DATA    = WRITE ? wdata_q : '0;
    assign CSEL       = (WRITE || state == R_PCH || state == R_WL) ? '1 : '0;
    assign wl_on      = (state == W_WL) || (state == R_WL) || (state == R_SENSE);

    // Rows beyond numRows match no index, leaving WL all-zero.
    always_comb begin
        WL = '0;
        for (int i = 0; i < numRows; i++)
            WL[i] = wl_on && (int'(addr_q) == i);
    end
endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Directed + randomized bench for qracc_sram_ctrl with an analog array model and a
// reference memory; honours QRACC_WRITE_VERIFY_EN when defined.
module tb_qracc_sram_ctrl;
    localparam int ROWS  = 128;
    localparam int COLS  = 32;
    localparam int AW    = 7;
    localparam int PCH_C = 3;
    localparam int WL_C  = 2;
`ifdef QRACC_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int W_OCC = VERIFY ? (2 * WL_C + PCH_C + 3) : (WL_C + 2);
    localparam int R_LAT = PCH_C + WL_C + 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rq_valid = 1'b0;
    logic            rq_wr = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [COLS-1:0] wr_data = '0;
    logic            mac_en = 1'b0;
    logic            rq_ready_o, rd_valid_o, busy_o, PCH, WRITE, SAEN, wr_err_o;
    logic [COLS-1:0] rd_data_o, WR_DATA, CSEL, SA_OUT;
    logic [ROWS-1:0] WL;

    int vectors = 0;
    int miscompares = 0;
    logic [COLS-1:0] arr [ROWS];
    logic [COLS-1:0] ref_mem [ROWS];
    logic [COLS-1:0] stuck_mask = '0;
    logic [COLS-1:0] exp_q [$];
    logic            exp_err = 1'b0;

    always #5 clk = ~clk;

    qracc_sram_ctrl #(
        .numRows(ROWS), .numCols(COLS), .pchCycles(PCH_C), .wlCycles(WL_C)
    ) dut (
        .clk(clk), .rst(rst), .rq_valid_i(rq_valid), .rq_wr_i(rq_wr), .addr_i(addr),
        .wr_data_i(wr_data), .rq_ready_o(rq_ready_o), .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o), .mac_en_i(mac_en), .busy_o(busy_o), .WL(WL), .PCH(PCH),
        .WRITE(WRITE), .WR_DATA(WR_DATA), .CSEL(CSEL), .SAEN(SAEN), .SA_OUT(SA_OUT),
        .wr_err_o(wr_err_o)
    );

    // Analog array: stores on write-drive with a word line, senses the selected row.
    always @(posedge clk)
        if (WRITE)
            for (int r = 0; r < ROWS; r++)
                if (WL[r]) arr[r] <= WR_DATA & ~stuck_mask;

    always_comb begin
        SA_OUT = '0;
        if (SAEN)
            for (int r = 0; r < ROWS; r++)
                if (WL[r]) SA_OUT = SA_OUT | arr[r];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk)
        if (!rst) begin
            check("wl_onehot0", 128'($onehot0(WL)), 128'd1);
            check("pch_wl_excl", 128'(PCH && (|WL)), 128'd0);
        end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!rq_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 128'(n < 100), 128'd1);
    endtask

    task automatic scramble_inputs();
        rq_valid = 1'b0;
        rq_wr    = 1'($urandom);
        addr     = AW'($urandom);
        wr_data  = COLS'($urandom);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [COLS-1:0] d);
        int wl_n = 0;
        int wr_n = 0;
        int rv_n = 0;
        logic [ROWS-1:0] oh;
        oh = '0;
        oh[a] = 1'b1;
        wait_ready("wr_ready_wait");
        rq_valid = 1'b1; rq_wr = 1'b1; addr = a; wr_data = d;
        for (int k = 1; k <= W_OCC; k++) begin
            @(negedge clk);
            if (k == 1) begin
                scramble_inputs();
                check("wr_err_cleared", 128'(wr_err_o), 128'd0);
                check("wr_setup_data", 128'(WR_DATA), 128'(d));
                check("wr_setup_csel", 128'(CSEL), 128'({COLS{1'b1}}));
            end
            if (k == WL_C + 2) begin
                check("wr_rec_wl", 128'(WL), 128'd0);
                check("wr_rec_write", 128'(WRITE), 128'd1);
            end
            if (WL == oh && !SAEN) wl_n++;
            if (WRITE) wr_n++;
            if (rd_valid_o) rv_n++;
        end
        ref_mem[a] = d & ~stuck_mask;
        exp_err = VERIFY && ((d & ~stuck_mask) != d);
        check("wr_wl_cycles", 128'(wl_n), 128'(VERIFY ? 2 * WL_C : WL_C));
        check("wr_write_cycles", 128'(wr_n), 128'(WL_C + 2));
        check("wr_no_rd_valid", 128'(rv_n), 128'd0);
        @(negedge clk);
        check("wr_ready_after", 128'(rq_ready_o), 128'd1);
        check("wr_busy_after", 128'(busy_o), 128'd0);
        check("wr_err", 128'(wr_err_o), 128'(exp_err));
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit raise_mac);
        int pch_n = 0;
        int wl_n = 0;
        int rv_n = 0;
        int rv_k = 0;
        logic [ROWS-1:0] oh;
        oh = '0;
        oh[a] = 1'b1;
        exp_q.push_back(ref_mem[a]);
        wait_ready("rd_ready_wait");
        rq_valid = 1'b1; rq_wr = 1'b0; addr = a;
        for (int k = 1; k <= R_LAT; k++) begin
            @(negedge clk);
            if (k == 1) begin
                scramble_inputs();
                check("rd_pch_csel", 128'(CSEL), 128'({COLS{1'b1}}));
            end
            if (k == 2 && raise_mac) mac_en = 1'b1;
            if (PCH) pch_n++;
            if (WL == oh && !SAEN) wl_n++;
            if (SAEN) check("rd_sense_wl", 128'(WL), 128'(oh));
            if (rd_valid_o) begin
                rv_n++;
                rv_k = k;
                if (exp_q.size() > 0) check("rd_data", 128'(rd_data_o), 128'(exp_q.pop_front()));
            end
        end
        check("rd_pch_cycles", 128'(pch_n), 128'(PCH_C));
        check("rd_wl_cycles", 128'(wl_n), 128'(WL_C));
        check("rd_valid_count", 128'(rv_n), 128'd1);
        check("rd_latency", 128'(rv_k), 128'(R_LAT));
        @(negedge clk);
        check("rd_valid_drop", 128'(rd_valid_o), 128'd0);
        check("rd_ready_after", 128'(rq_ready_o), 128'(!raise_mac));
        check("rd_busy_after", 128'(busy_o), 128'd0);
        mac_en = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [ROWS-1:0] oh7;
        int rv_n;

        // Reset values
        @(negedge clk);
        check("rst_wl", 128'(WL), 128'd0);
        check("rst_ctrl", 128'({PCH, WRITE, SAEN, rd_valid_o, busy_o, rq_ready_o, wr_err_o}), 128'd0);
        check("rst_buses", 128'({WR_DATA, CSEL, rd_data_o}), 128'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", 128'(rq_ready_o), 128'd1);

        // Write then read, pulse widths and latency with pch=3, wl=2
        do_write(AW'(5), 32'hDEADBEEF);
        do_read(AW'(5), 1'b0);

        // Full sweep
        for (int i = 0; i < ROWS; i++) do_write(AW'(i), COLS'(i));
        for (int i = 0; i < ROWS; i++) do_read(AW'(i), 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            ra = AW'($urandom_range(0, ROWS - 1));
            if ($urandom_range(0, 1) == 1) do_write(ra, COLS'($urandom));
            else                           do_read(ra, 1'b0);
        end

        // MAC rising mid-read: access completes, ready stays low
        do_read(AW'($urandom_range(0, ROWS - 1)), 1'b1);

        // MAC blocking with valid held
        mac_en = 1'b1; rq_valid = 1'b1; rq_wr = 1'b1; addr = AW'(3); wr_data = 32'hA5A50F0F;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("mac_ready", 128'(rq_ready_o), 128'd0);
            check("mac_write", 128'(WRITE), 128'd0);
            check("mac_wl", 128'(WL), 128'd0);
            check("mac_busy", 128'(busy_o), 128'd0);
        end
        mac_en = 1'b0;
        @(negedge clk);
        check("mac_release_busy", 128'(busy_o), 128'd1);
        check("mac_release_write", 128'(WRITE), 128'd1);
        rq_valid = 1'b0;
        ref_mem[3] = 32'hA5A50F0F;
        repeat (W_OCC) @(negedge clk);
        check("mac_release_done", 128'(rq_ready_o), 128'd1);
        do_read(AW'(3), 1'b0);

        // Reset during R_WL
        oh7 = '0;
        oh7[7] = 1'b1;
        wait_ready("rstmid_ready_wait");
        rq_valid = 1'b1; rq_wr = 1'b0; addr = AW'(7);
        @(negedge clk);
        rq_valid = 1'b0;
        repeat (PCH_C) @(negedge clk);
        check("rstmid_in_wl", 128'(WL), 128'(oh7));
        rst = 1'b1;
        #1;
        check("rstmid_wl", 128'(WL), 128'd0);
        check("rstmid_pch", 128'(PCH), 128'd0);
        check("rstmid_rd_valid", 128'(rd_valid_o), 128'd0);
        check("rstmid_rd_data", 128'(rd_data_o), 128'd0);
        check("rstmid_busy", 128'(busy_o), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_ready", 128'(rq_ready_o), 128'd1);
        rv_n = 0;
        for (int k = 0; k < R_LAT + 2; k++) begin
            @(negedge clk);
            if (rd_valid_o) rv_n++;
        end
        check("rstmid_no_rd_valid", 128'(rv_n), 128'd0);
        do_read(AW'(7), 1'b0);

`ifdef QRACC_WRITE_VERIFY_EN
        // Column 0 stuck at 0: writing 1 flags an error, writing 0 clears it
        stuck_mask = 32'h1;
        do_write(AW'(9), 32'h1);
        check("verify_err_set", 128'(wr_err_o), 128'd1);
        do_write(AW'(9), 32'h0);
        check("verify_err_clear", 128'(wr_err_o), 128'd0);
        stuck_mask = '0;
`endif

        check("exp_q_drained", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
